// File: rtl/bus_pkg.sv
// Shared definitions for the multiplexed 8-bit processor bus: the cycle-state
// encoding, strobe idle level, default widths and the I/O decode window used
// by the responders. Optional macro BUS_CYCLE_MASTER_READY_EN adds the TW state.
package bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // RD/WR are active low, so the released level is 1
  localparam logic STROBE_IDLE = 1'b1;

  // I/O space decoded by the responders when IOM=1
  localparam logic [15:0] IO_BASE = 16'hFF00;
  localparam logic [15:0] IO_LAST = 16'hFF0F;

`ifdef BUS_CYCLE_MASTER_READY_EN
  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_T1   = 6'b000010,
    ST_T2   = 6'b000100,
    ST_T3   = 6'b001000,
    ST_T4   = 6'b010000,
    ST_TW   = 6'b100000
  } cyc_state_t;
`else
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_T1   = 5'b00010,
    ST_T2   = 5'b00100,
    ST_T3   = 5'b01000,
    ST_T4   = 5'b10000
  } cyc_state_t;
`endif

  function automatic logic in_io_window(input logic [15:0] addr);
    return (addr >= IO_BASE) && (addr <= IO_LAST);
  endfunction

endpackage

// File: rtl/bus_cycle_master.sv
// Bus initiator: turns one core request at a time into a T1-T4 bus cycle on
// the multiplexed 8-bit bus and returns read data with a one-cycle response.
// Optional macro BUS_CYCLE_MASTER_READY_EN adds the READY input, the TW wait
// state and a wait-cycle timeout that reports rsp_err.
module bus_cycle_master
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef BUS_CYCLE_MASTER_READY_EN
  ,
  parameter int WAIT_MAX = 15
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_iom,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ALE,
  output logic              IOM,
  output logic              RD,
  output logic              WR,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data
`ifdef BUS_CYCLE_MASTER_READY_EN
  ,
  input  logic              READY
`endif
);

  cyc_state_t        state_reg, state_next;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              iom_reg;
  logic              ale_reg;
  logic              rd_reg;
  logic              wr_reg;
  logic              data_oe_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              accept;
  logic              strobe_next;
  logic              cycle_done;
  logic              timeout;

  // New work is taken only when idle or in the last phase of a cycle
  assign req_ready  = !RESET && ((state_reg == ST_IDLE) || (state_reg == ST_T4));
  assign accept     = req_valid && req_ready;
  // T4 is only ever entered from the data phase, so this marks completion
  assign cycle_done = (state_next == ST_T4);

`ifdef BUS_CYCLE_MASTER_READY_EN
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] wait_cnt_reg;

  assign timeout     = (state_reg == ST_TW) && !READY && (wait_cnt_reg == WAIT_LAST);
  assign strobe_next = (state_next == ST_T2) || (state_next == ST_T3) || (state_next == ST_TW);

  // Count wait states; the value equals the index of the current TW cycle
  always_ff @(posedge CLK) begin
    if (RESET)
      wait_cnt_reg <= '0;
    else if (state_next == ST_TW)
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    else
      wait_cnt_reg <= '0;
  end
`else
  assign timeout     = 1'b0;
  assign strobe_next = (state_next == ST_T2) || (state_next == ST_T3);
`endif

  // Cycle sequencing: IDLE -> T1 -> T2 -> T3 (-> TW) -> T4 -> T1/IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3: begin
        state_next = ST_T4;
`ifdef BUS_CYCLE_MASTER_READY_EN
        if (!READY) state_next = ST_TW;
`endif
      end
`ifdef BUS_CYCLE_MASTER_READY_EN
      ST_TW:   if (READY || timeout) state_next = ST_T4;
`endif
      ST_T4:   state_next = accept ? ST_T1 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, registered bus outputs, request latch and response capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= ST_IDLE;
      write_reg     <= 1'b0;
      wdata_reg     <= '0;
      addr_reg      <= '0;
      iom_reg       <= 1'b0;
      ale_reg       <= 1'b0;
      rd_reg        <= STROBE_IDLE;
      wr_reg        <= STROBE_IDLE;
      data_oe_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ale_reg       <= (state_next == ST_T1);
      rd_reg        <= ~(strobe_next && !write_reg);
      wr_reg        <= ~(strobe_next && write_reg);
      data_oe_reg   <= strobe_next && write_reg;
      rsp_valid_reg <= cycle_done;
      rsp_err_reg   <= cycle_done && timeout;
      if (accept) begin
        write_reg <= req_write;
        wdata_reg <= req_wdata;
        addr_reg  <= req_addr;
        iom_reg   <= req_iom;
      end
      // Bus data is sampled on the edge that leaves the data phase
      if (cycle_done)
        rsp_rdata_reg <= (write_reg || timeout) ? '0 : Data;
    end
  end

  assign Data      = data_oe_reg ? wdata_reg : 'z;
  assign ALE       = ale_reg;
  assign IOM       = iom_reg;
  assign RD        = rd_reg;
  assign WR        = wr_reg;
  assign Address   = addr_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Self-checking bench for bus_cycle_master: directed table of transactions,
// back-to-back and mid-cycle reset sequences, then random traffic checked each
// cycle against a timeline model (cycle offset from the accept edge).
module tb_bus_cycle_master;
  import bus_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_iom = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, ALE, IOM, RD, WR;
  logic [7:0]  rsp_rdata;
  logic [15:0] Address;
  wire  [7:0]  Data;
`ifdef BUS_CYCLE_MASTER_READY_EN
  logic        READY = 1'b1;
  localparam int TB_WAIT_MAX = 15;
`endif

  always #5 CLK = ~CLK;

  bus_cycle_master dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_iom(req_iom), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .Address(Address), .Data(Data)
`ifdef BUS_CYCLE_MASTER_READY_EN
    , .READY(READY)
`endif
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a == 16'hFF03) ? 8'h5A : (a[7:0] ^ 8'h96);
  endfunction

  // Responder: drives memory on reads; whenever WR is high and nothing is read
  // it drives a marker 3C, so a master that fails to release Data is visible.
  logic [7:0] resp_mem [0:65535];
  assign Data = WR ? (RD ? 8'h3C : resp_mem[Address]) : 8'hzz;

  // Responder memory: restored on reset, written while WR is low
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 65536; i++) resp_mem[i] <= init_val(16'(i));
    end else if (!WR) begin
      resp_mem[Address] <= Data;
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [0:65535];
  int          n = 0, checks = 0, errors = 0, acc_n = 0;
  bit          model_on = 1'b0, act = 1'b0, acc_flag = 1'b0;
  bit          t_w, t_io;
  logic [15:0] t_addr, last_addr = '0;
  logic [7:0]  t_wd, t_pred;
  logic        last_iom = 1'b0;
  int          ale_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, n);
    end
  endtask

  // One bus cycle: drive inputs, compare outputs against the timeline model,
  // advance the model, move to the next sample point.
  task automatic step(input bit rst, input bit v, input bit w, input bit io,
                      input logic [15:0] ad, input logic [7:0] wd);
    int          off;
    bit          e_ready, in_data;
    logic [7:0]  e_data;
    logic [30:0] expv, gotv;
    RESET = rst; req_valid = v; req_write = w; req_iom = io;
    req_addr = ad; req_wdata = wd;
    #1;
    off     = act ? (n - acc_n) : 0;
    in_data = (off == 2) || (off == 3);
    e_ready = !rst && ((off == 0) || (off == 4));
    e_data  = in_data ? (t_w ? t_wd : t_pred) : 8'h3C;
    expv = {e_ready, (off == 4), 1'b0, (off == 1), last_iom,
            !(in_data && !t_w), !(in_data && t_w), last_addr, e_data};
    gotv = {req_ready, rsp_valid, rsp_err, ALE, IOM, RD, WR, Address, Data};
    if (ALE) ale_q.push_back(n);
    if (model_on) begin
      chk("bus{rdy,rv,err,ale,iom,rd,wr,addr,data}", 64'(gotv), 64'(expv));
      if (off == 4) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(t_pred));
        $display("txn cyc=%0d %s %s addr=%h data=%h", n, t_w ? "WR" : "RD",
                 in_io_window(t_addr) ? "IO " : "MEM", t_addr, t_w ? t_wd : rsp_rdata);
      end
    end
    acc_flag = 1'b0;
    if (rst) begin
      act = 1'b0; last_addr = '0; last_iom = 1'b0;
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    end else if (v && e_ready) begin
      act = 1'b1; acc_n = n; acc_flag = 1'b1;
      t_w = w; t_io = io; t_addr = ad; t_wd = wd;
      t_pred = w ? 8'h00 : ref_mem[ad];
      if (w) ref_mem[ad] = wd;
      last_addr = ad; last_iom = io;
    end else if (off == 4) begin
      act = 1'b0;
    end
    @(posedge CLK); #1;
    n++;
  endtask

  // Hold a request until the model sees it accepted (bounded)
  task automatic run_req(input bit w, input bit io, input logic [15:0] ad, input logic [7:0] wd);
    int tries = 0;
    do begin
      step(0, 1, w, io, ad, wd);
      tries++;
    end while (!acc_flag && tries < 12);
    if (!acc_flag) chk("accept_timeout", 64'(0), 64'(1));
    req_valid = 1'b0;
  endtask

  typedef struct {
    bit          w;
    bit          io;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{w: 1'b0, io: 1'b1, addr: 16'hFF03, wd: 8'h00, exp: 8'h5A};
    tbl[1] = '{w: 1'b1, io: 1'b1, addr: 16'hFF07, wd: 8'hC3, exp: 8'h00};
    tbl[2] = '{w: 1'b0, io: 1'b1, addr: 16'hFF07, wd: 8'h00, exp: 8'hC3};
    tbl[3] = '{w: 1'b0, io: 1'b0, addr: 16'h0010, wd: 8'h00, exp: 8'h86};
    tbl[4] = '{w: 1'b1, io: 1'b0, addr: 16'h0010, wd: 8'hA7, exp: 8'h00};
    tbl[5] = '{w: 1'b0, io: 1'b0, addr: 16'h0010, wd: 8'h00, exp: 8'hA7};

    // Reset: one unchecked edge, then three checked reset cycles
    @(posedge CLK); #1;
    model_on = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, '0);
    chk("reset_rdata", 64'(rsp_rdata), 64'(0));
    step(0, 0, 0, 0, '0, '0);

    // Directed table: each transaction runs to its response at accept+4
    for (int i = 0; i < 6; i++) begin
      run_req(tbl[i].w, tbl[i].io, tbl[i].addr, tbl[i].wd);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0, '0);
      chk("tbl_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("tbl_rsp_rdata", 64'(rsp_rdata), 64'(tbl[i].exp));
      step(0, 0, 0, 0, '0, '0);
    end

    // Back-to-back reads with req_valid held: ALE every 4 cycles
    ale_q.delete();
    for (int i = 0; i < 3; i++) run_req(0, 1, 16'hFF00 + 16'(i), '0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, '0, '0);
    chk("b2b_ale_count", 64'(ale_q.size()), 64'(3));
    if (ale_q.size() == 3) begin
      chk("b2b_ale_gap0", 64'(ale_q[1] - ale_q[0]), 64'(4));
      chk("b2b_ale_gap1", 64'(ale_q[2] - ale_q[1]), 64'(4));
    end

    // Reset during T2 of a write, then a normal read completes
    run_req(1, 0, 16'h0020, 8'h5E);
    step(0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, '0, '0);
    chk("rst_mid_wr", 64'(WR), 64'(1));
    run_req(0, 0, 16'h0030, '0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0, '0);
    chk("post_rst_rdata", 64'(rsp_rdata), 64'(8'h30 ^ 8'h96));
    step(0, 0, 0, 0, '0, '0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bit          rv, rw, rio;
      logic [15:0] ra;
      rv  = ($urandom_range(0, 9) < 6);
      rw  = 1'($urandom_range(0, 1));
      rio = 1'($urandom_range(0, 1));
      ra  = rio ? (IO_BASE + 16'($urandom_range(0, 15))) : 16'($urandom_range(0, 31));
      step(0, rv, rw, rio, ra, 8'($urandom_range(0, 255)));
    end
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, '0, '0);

`ifdef BUS_CYCLE_MASTER_READY_EN
    begin
      int rd_low;
      bit got;
      step(1, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);
      model_on = 1'b0;
      // READY low for T3 and two waits: RD low 5 cycles
      req_valid = 1'b1; req_write = 1'b0; req_iom = 1'b1; req_addr = 16'hFF03;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      rd_low = 0; got = 1'b0;
      for (int k = 1; k <= 30 && !got; k++) begin
        READY = (k >= 6);
        if (!RD) rd_low++;
        if (rsp_valid) begin
          got = 1'b1;
          chk("wait_rdata", 64'(rsp_rdata), 64'(8'h5A));
          chk("wait_err", 64'(rsp_err), 64'(0));
        end
        @(posedge CLK); #1;
      end
      chk("wait_rsp_seen", 64'(got), 64'(1));
      chk("wait_rd_low", 64'(rd_low), 64'(5));
      // READY stuck low: timeout after TB_WAIT_MAX waits
      READY = 1'b0;
      @(posedge CLK); #1;
      req_valid = 1'b1; req_addr = 16'hFF01;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      rd_low = 0; got = 1'b0;
      for (int k = 1; k <= 60 && !got; k++) begin
        if (!RD) rd_low++;
        if (rsp_valid) begin
          got = 1'b1;
          chk("tmo_err", 64'(rsp_err), 64'(1));
          chk("tmo_rdata", 64'(rsp_rdata), 64'(0));
        end
        @(posedge CLK); #1;
      end
      chk("tmo_rsp_seen", 64'(got), 64'(1));
      chk("tmo_rd_low", 64'(rd_low), 64'(TB_WAIT_MAX + 2));
      READY = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_cycle_master.md
Name: bus_cycle_master

Overview:
- Initiator side of the multiplexed 8-bit processor bus (ALE, IOM, RD, WR, 16-bit Address, 8-bit bidirectional Data).
- Converts single-transaction requests from a core-side valid/ready port into T1–T4 bus cycles.
- Drives one read or write cycle at a time and returns read data to the core.
- Sits between the CPU core model and the memory and I/O responders on the shared bus.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 8, bus data width.
- WAIT_MAX, 15, maximum wait cycles before a cycle is aborted (used only with the optional feature).

Ports:
- CLK  input  1  bus clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- req_valid  input  1  core request present.
- req_ready  output  1  master can accept a request this cycle.
- req_write  input  1  1 = write cycle, 0 = read cycle.
- req_iom  input  1  value to drive on IOM (1 = I/O space, 0 = memory).
- req_addr  input  ADDR_W  target address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle pulse when a cycle completes.
- rsp_rdata  output  DATA_W  captured read data; 0 after a write.
- rsp_err  output  1  cycle aborted by timeout; tied 0 without the optional feature.
- ALE  output  1  address latch enable, high during T1 only.
- IOM  output  1  memory/I-O select.
- RD  output  1  active-low read strobe.
- WR  output  1  active-low write strobe.
- Address  output  ADDR_W  bus address.
- Data  inout  DATA_W  bus data; driven by this block only during write T2–T3, otherwise high-Z.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high, on RESET. All bus outputs are registered.
- Reset values (from the first edge with RESET=1):
  - state IDLE, ALE=0, IOM=0, RD=1, WR=1, Address=0, Data=Z
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
- State encoding: one-hot 5-bit IDLE, T1, T2, T3, T4. A sixth state, TW, exists only under the macro.
- Handshake:
  - req_ready=1 in IDLE and T4, when RESET=0.
  - Accept on posedge with req_valid && req_ready.
  - Request fields are latched internally; the core may change them afterwards.
- Transitions:
  - IDLE → T1 on accept.
  - T1 → T2 → T3 → T4, one cycle each.
  - T4 → T1 on accept (back-to-back), else T4 → IDLE.
- Per-state outputs:
  - T1: ALE=1, Address and IOM valid. Address and IOM then hold through T4 and hold their last value in IDLE.
  - T2: ALE=0. Read: RD=0. Write: WR=0 and Data=wdata.
  - T3: strobe held low. Write data held on Data.
  - T4: RD=1, WR=1, Data=Z.
- Read capture: Data is sampled into rsp_rdata on the posedge leaving T3.
- Response: rsp_valid=1 for exactly the T4 cycle; rsp_rdata is valid while rsp_valid=1.
- Latency: accept edge to rsp_valid is 4 cycles. Sustained throughput is one transaction per 4 cycles.
- Strobe exclusivity: RD and WR are never low simultaneously, and neither is low while ALE=1.
- Reset mid-cycle: strobes release at the next edge, the transaction is dropped, and no rsp_valid is generated.
- req_valid outside IDLE/T4 is ignored; the request is not latched.

Optional Feature:
- Macro: BUS_CYCLE_MASTER_READY_EN.
- With the macro defined:
  - Adds input port READY (1 bit).
  - In T3, if READY=0, go to TW. Strobes stay low and write data stays driven.
  - TW → T4 when READY=1; data is captured on that edge for reads.
  - A counter tracks wait cycles. When the count reaches WAIT_MAX, go to T4 with rsp_err=1 and rsp_rdata=0.
- Without the macro: no READY port, T3 is always one cycle, rsp_err is tied 0.

Decomposition:
- Shared package bus_pkg holds:
  - the one-hot cycle-state enum
  - the RD/WR active-low idle constant
  - the ADDR_W/DATA_W defaults
  - the I/O window constants IO_BASE=16'hFF00 and IO_LAST=16'hFF0F, shared with the responders
- No sub-module; the tristate Data driver stays inline as a continuous assignment.

Test Plan:
- Reset release: hold RESET 3 cycles → RD=1, WR=1, ALE=0, Data=Z, req_ready=0 during reset and 1 on the first IDLE cycle.
- I/O read: bench responder preloaded with FF03=8'h5A; request read, iom=1, addr 16'hFF03.
  - ALE=1 only in T1; RD=0 in T2–T3.
  - rsp_valid on accept+4 with rsp_rdata=8'h5A.
- I/O write then readback: write 8'hC3 to 16'hFF07.
  - WR=0 in T2–T3 with Data=8'hC3; Data=Z in T4.
  - A following read of FF07 returns 8'hC3.
- Back-to-back: req_valid held for 3 reads of FF00, FF01, FF02.
  - ALE pulses 4 cycles apart; no IDLE between cycles; 3 rsp_valid pulses in order.
- Reset in T2 of a write: WR=1 and Data=Z on the next edge, no rsp_valid, next request completes normally.
- With BUS_CYCLE_MASTER_READY_EN:
  - READY low 3 cycles → RD held low 5 cycles, then correct rdata.
  - READY stuck low → rsp_err=1 after WAIT_MAX waits.
